// File: rtl/bmu_wb_buffer.sv
// Writeback buffer behind the BMU: tracks issued tags through the fixed result latency,
// captures results into a show-ahead FIFO and returns credit so the non-stalling BMU never overflows it.
module bmu_wb_buffer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned TAG_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       issue_valid,
    input  logic [TAG_W-1:0]           issue_tag,
    input  logic [31:0]                result_ff,
    input  logic                       error,
    output logic                       issue_ready,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [31:0]                wb_data,
    output logic [TAG_W-1:0]           wb_tag,
    output logic                       wb_error,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [7:0]                 err_cnt,
    output logic                       overflow
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [TAG_W-1:0]   pipe_tag_q [LATENCY];
    logic [TAG_W-1:0]   pipe_tag_d [LATENCY];

    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      err_cnt_q, err_cnt_d;
    logic            overflow_q, overflow_d;

    logic [31:0]      mem_data [DEPTH];
    logic [TAG_W-1:0] mem_tag  [DEPTH];
    logic             mem_err  [DEPTH];

    logic [31:0] inflight;
    logic        issue_acc;
    logic        push;
    logic        pop;

    // Credit counts results already buffered plus results still inside the BMU.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight = inflight + 32'(pipe_vld_q[i]);
        end
    end

    assign issue_ready = (32'(count_q) + inflight) < DEPTH;
    assign wb_valid    = (count_q != '0);
    assign issue_acc   = issue_valid & issue_ready & ~flush;
    assign push        = pipe_vld_q[LATENCY-1] & ~flush;
    assign pop         = wb_valid & wb_ready & ~flush;

    always_comb begin
        pipe_vld_d    = '0;
        pipe_tag_d[0] = issue_tag;
        pipe_vld_d[0] = issue_acc;
        for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_d[i] = pipe_vld_q[i-1];
            pipe_tag_d[i] = pipe_tag_q[i-1];
        end
        if (flush) begin
            pipe_vld_d = '0;
        end
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        err_cnt_d  = err_cnt_q;
        overflow_d = overflow_q;

        if (issue_valid && !issue_ready && !flush) begin
            overflow_d = 1'b1;
        end

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
                if (error && err_cnt_q != 8'hff) begin
                    err_cnt_d = err_cnt_q + 8'd1;
                end
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_vld_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            err_cnt_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            pipe_vld_q <= pipe_vld_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            err_cnt_q  <= err_cnt_d;
            overflow_q <= overflow_d;
        end
    end

    // Tags and storage carry no reset; they are qualified by the valid bits and count.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LATENCY; i++) begin
            pipe_tag_q[i] <= pipe_tag_d[i];
        end
        if (push) begin
            mem_data[wr_ptr_q] <= result_ff;
            mem_tag[wr_ptr_q]  <= pipe_tag_q[LATENCY-1];
            mem_err[wr_ptr_q]  <= error;
        end
    end

    // Head is gated by wb_valid so an empty buffer always presents zeros.
    always_comb begin
        wb_data  = '0;
        wb_tag   = '0;
        wb_error = 1'b0;
        if (wb_valid) begin
            wb_data  = mem_data[rd_ptr_q];
            wb_tag   = mem_tag[rd_ptr_q];
            wb_error = mem_err[rd_ptr_q];
        end
    end

    assign count    = count_q;
    assign err_cnt  = err_cnt_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bmu_wb_buffer.sv
// Randomized bench for bmu_wb_buffer against a queue-based model of in-flight ops and buffered results.
module tb_bmu_wb_buffer;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned LATENCY = 1;
    localparam int unsigned TAG_W   = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             flush = 1'b0;
    logic             issue_valid = 1'b0;
    logic [TAG_W-1:0] issue_tag = '0;
    logic [31:0]      result_ff = '0;
    logic             error = 1'b0;
    logic             issue_ready;
    logic             wb_valid;
    logic             wb_ready = 1'b0;
    logic [31:0]      wb_data;
    logic [TAG_W-1:0] wb_tag;
    logic             wb_error;
    logic [2:0]       count;
    logic [7:0]       err_cnt;
    logic             overflow;

    bmu_wb_buffer #(
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .issue_valid(issue_valid),
        .issue_tag  (issue_tag),
        .result_ff  (result_ff),
        .error      (error),
        .issue_ready(issue_ready),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_data    (wb_data),
        .wb_tag     (wb_tag),
        .wb_error   (wb_error),
        .count      (count),
        .err_cnt    (err_cnt),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TAG_W-1:0] tag;
        int               due;
    } pend_t;

    typedef struct {
        logic [31:0]      data;
        logic [TAG_W-1:0] tag;
        logic             err;
    } ent_t;

    pend_t m_pend[$];
    ent_t  m_fifo[$];
    int    m_err = 0;
    logic  m_ovf = 1'b0;
    int    cyc   = 0;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_model();
        logic exp_ready;
        exp_ready = (m_fifo.size() + m_pend.size()) < DEPTH;
        check_eq("count", 32'(count), m_fifo.size());
        check_eq("wb_valid", 32'(wb_valid), 32'(m_fifo.size() != 0));
        check_eq("issue_ready", 32'(issue_ready), 32'(exp_ready));
        check_eq("err_cnt", 32'(err_cnt), m_err);
        check_eq("overflow", 32'(overflow), 32'(m_ovf));
        if (m_fifo.size() != 0) begin
            check_eq("wb_data", wb_data, m_fifo[0].data);
            check_eq("wb_tag", 32'(wb_tag), 32'(m_fifo[0].tag));
            check_eq("wb_error", 32'(wb_error), 32'(m_fifo[0].err));
        end
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_wb_valid", 32'(wb_valid), 0);
        check_eq("rst_issue_ready", 32'(issue_ready), 1);
        check_eq("rst_wb_data", wb_data, 0);
        check_eq("rst_wb_tag", 32'(wb_tag), 0);
        check_eq("rst_wb_error", 32'(wb_error), 0);
        check_eq("rst_count", 32'(count), 0);
        check_eq("rst_err_cnt", 32'(err_cnt), 0);
        check_eq("rst_overflow", 32'(overflow), 0);
    endtask

    // Entered at posedge+1: drive, check, advance model, step one clock.
    task automatic cycle(input logic iv, input logic [TAG_W-1:0] tg, input logic [31:0] res,
                         input logic er, input logic wr, input logic fl);
        logic  exp_valid;
        logic  exp_ready;
        ent_t  e;
        pend_t p;
        issue_valid = iv;
        issue_tag   = tg;
        result_ff   = res;
        error       = er;
        wb_ready    = wr;
        flush       = fl;
        #1;
        check_model();
        exp_valid = m_fifo.size() != 0;
        exp_ready = (m_fifo.size() + m_pend.size()) < DEPTH;
        if (fl) begin
            m_pend.delete();
            m_fifo.delete();
        end else begin
            if (exp_valid && wr) void'(m_fifo.pop_front());
            if (m_pend.size() != 0 && m_pend[0].due == cyc) begin
                e.data = res;
                e.tag  = m_pend[0].tag;
                e.err  = er;
                m_fifo.push_back(e);
                void'(m_pend.pop_front());
                if (er && m_err < 255) m_err++;
            end
            if (iv) begin
                if (exp_ready) begin
                    p.tag = tg;
                    p.due = cyc + LATENCY;
                    m_pend.push_back(p);
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic wr);
        cycle(1'b0, '0, $urandom, 1'b0, wr, 1'b0);
    endtask

    task automatic async_reset();
        issue_valid = 1'b0;
        flush       = 1'b0;
        wb_ready    = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        m_pend.delete();
        m_fifo.delete();
        m_err = 0;
        m_ovf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #12;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single op, tag 3.
        cycle(1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 5'd0, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0);
        check_eq("single_valid", 32'(wb_valid), 1);
        check_eq("single_data", wb_data, 32'hDEADBEEF);
        idle(1'b1);
        check_eq("single_drained", 32'(count), 0);
        idle(1'b1);

        // Fill to credit limit, then an overflow attempt.
        for (int i = 1; i <= 4; i++) cycle(1'b1, 5'(i), $urandom, 1'b0, 1'b0, 1'b0);
        check_eq("fill_ready", 32'(issue_ready), 0);
        cycle(1'b1, 5'd5, $urandom, 1'b0, 1'b0, 1'b0);
        check_eq("fill_ovf", 32'(overflow), 1);
        check_eq("fill_count", 32'(count), 4);
        for (int i = 0; i < 6; i++) idle(1'b1);

        // Back-to-back with continuous drain; pointers wrap.
        for (int i = 0; i < 10; i++) cycle(1'b1, 5'(i), 32'(i), 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Backpressure hold.
        cycle(1'b1, 5'd7, $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 5'd0, 32'h12345678, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b0);
        idle(1'b1);
        idle(1'b1);

        // Errors, then saturation.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 5'(i), $urandom, 1'($urandom), 1'b1, 1'b0);
        end
        for (int i = 0; i < 300; i++) cycle(1'b1, 5'($urandom), $urandom, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);
        check_eq("err_sat", 32'(err_cnt), 255);

        // Flush with two buffered and one in flight.
        for (int i = 0; i < 3; i++) cycle(1'b1, 5'(i + 20), $urandom, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 5'd9, $urandom, 1'b1, 1'b1, 1'b1);
        check_eq("flush_count", 32'(count), 0);
        check_eq("flush_ready", 32'(issue_ready), 1);
        for (int i = 0; i < 3; i++) idle(1'b1);

        async_reset();

        // Random traffic with occasional flushes and a mid-run reset.
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) async_reset();
            cycle(1'($urandom_range(0, 9) < 7), 5'($urandom), $urandom, 1'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bmu_wb_buffer.md
Name: bmu_wb_buffer

Overview:
- Stage directly downstream of the bit-manipulation unit (BMU).
- Tracks each issued BMU operation's destination tag through the BMU's fixed result latency and captures result_ff and error when they become valid.
- Buffers completed results in a small FIFO and drains them to the register-file writeback port under a valid/ready handshake.
- The BMU cannot stall, so this block returns credit-based issue_ready upstream to prevent buffer overflow.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2
LATENCY, 1, cycles from BMU valid_in to result_ff valid; >= 1
TAG_W, 5, destination register tag width

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of in-flight ops and FIFO
issue_valid  in  1  asserted in the same cycle as BMU valid_in
issue_tag  in  TAG_W  destination tag of the issued op
result_ff  in  32  BMU result
error  in  1  BMU error flag, aligned with result_ff
issue_ready  out  1  upstream may issue this cycle
wb_valid  out  1  FIFO head valid
wb_ready  in  1  writeback consumer accepts head
wb_data  out  32  head result
wb_tag  out  TAG_W  head tag
wb_error  out  1  head error flag
count  out  $clog2(DEPTH+1)  FIFO occupancy
err_cnt  out  8  saturating count of buffered errored results
overflow  out  1  sticky: issue attempted while issue_ready=0

Behaviour:
- Reset (async, rst=1): pipeline valids, read/write pointers, count, err_cnt and overflow all 0. Outputs: wb_valid=0, issue_ready=1, wb_data/wb_tag/wb_error=0.
- Issue acceptance: issue accepted = issue_valid & issue_ready & !flush. An accepted issue enters a LATENCY-deep shift pipeline of {valid, tag}.
- Push: when the last pipeline stage is valid, write {result_ff, error, tag} at the write pointer in the same cycle.
  - The result is therefore captured exactly LATENCY cycles after the issue cycle.
- In-flight count: inflight = number of valid pipeline stages.
- Credit: issue_ready = (count + inflight) < DEPTH.
  - Computed from registered state only; it does not depend on wb_ready or issue_valid.
  - An accepted push can never find the FIFO full.
- Pop: pop = wb_valid & wb_ready.
  - Show-ahead: wb_data, wb_tag and wb_error always reflect the entry at the read pointer.
  - wb_valid = (count != 0).
  - wb_data/wb_tag/wb_error hold their value while wb_valid=1 and wb_ready=0.
- Push and pop in the same cycle: count unchanged, both pointers advance. Valid even when count = DEPTH (pop frees the slot first) and when count=0 is impossible for pop.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
- Empty/full state: wb_valid=0 when empty; issue_ready=0 when count + inflight = DEPTH.
- Latency: issue to wb_valid (when FIFO empty) = LATENCY + 1 cycles. Example LATENCY=1: issue at cycle N, push at N+1, wb_valid=1 at N+2.
- err_cnt: increments on every push with error=1 and saturates at 255. Cleared only by rst.
- overflow: set when issue_valid=1 and issue_ready=0 and flush=0. The issue is dropped (not tracked, not counted). Sticky until rst.
- Flush (priority over all other actions):
  - Next cycle: pipeline valids=0, pointers=0, count=0, wb_valid=0, issue_ready=1.
  - Issue, push and pop in the flush cycle are all discarded.
  - err_cnt and overflow are retained.
- rst asserted mid-operation: immediate async clear as above. In-flight and buffered results are lost.

Test Plan:
- Single op: rst then release; issue_tag=3 at cycle N with result_ff=0xDEADBEEF, error=0 at N+1; wb_ready=1 -> wb_valid=1 at N+2, wb_data=0xDEADBEEF, wb_tag=3, popped at N+2, count returns to 0 at N+3.
- Fill/credit: wb_ready=0; issue tags 1,2,3,4 back-to-back -> issue_ready=0 from the cycle after the 4th issue, count=4. A 5th issue_valid pulse sets overflow=1 and count stays 4. Then wb_ready=1 -> pops in order 1,2,3,4.
- Wrap and simultaneous push/pop: wb_ready=1 continuously; issue 10 consecutive ops with result_ff=i -> wb_data sequence 0..9 in order, count never exceeds 1, pointers wrap twice.
- Backpressure hold: head=0x12345678; wb_ready=0 for 3 cycles -> wb_data, wb_tag and wb_error stable and wb_valid=1 throughout; pop on the cycle wb_ready=1.
- Errors: 3 ops with error=1 and 1 with error=0 -> err_cnt=3, wb_error matches each entry. Force 300 errored ops -> err_cnt=255.
- Flush/reset: with count=2 and one op in flight, assert flush for 1 cycle -> next cycle count=0, wb_valid=0, issue_ready=1, and the in-flight result is not pushed. Assert rst asynchronously between clock edges -> outputs clear immediately.
